// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM between the core (port A) and a secondary requester (port B).
// Optional macro DMEM_ARB_RR_EN: round-robin on conflict instead of fixed priority with a starvation guard.
module dmem_arbiter #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 24,
  parameter int unsigned READ_LAT = 1,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int unsigned CNT_W = 4;

  logic                favour_b;
  logic                gnt_a;
  logic                gnt_b;
  logic                issue_rd;
  logic                issue_own;
  logic [READ_LAT-1:0] pipe_v;
  logic [READ_LAT-1:0] pipe_o;
  logic                ret_v;

`ifdef DMEM_ARB_RR_EN
  // Last-winner pointer: set means B takes the next conflict.
  logic prio_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_b <= 1'b0;
    end else if (gnt_a) begin
      prio_b <= 1'b1;
    end else if (gnt_b) begin
      prio_b <= 1'b0;
    end
  end

  assign favour_b = prio_b;
`else
  // Consecutive cycles B has been left waiting, saturating at MAX_WAIT.
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (b_req && !gnt_b) begin
      if (wait_cnt != CNT_W'(MAX_WAIT)) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
    end else begin
      wait_cnt <= '0;
    end
  end

  assign favour_b = (wait_cnt == CNT_W'(MAX_WAIT));
`endif

  // Winner selection; nothing is granted while reset is held.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (!reset) begin
      if (a_req && (!b_req || !favour_b)) begin
        gnt_a = 1'b1;
      end else if (b_req) begin
        gnt_b = 1'b1;
      end
    end
  end

  assign a_gnt = gnt_a;
  assign b_gnt = gnt_b;

  // RAM command mux; idle bus drives zeros.
  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_wren  = 1'b0;
    issue_rd  = 1'b0;
    issue_own = 1'b0;
    if (gnt_a) begin
      ram_addr  = a_addr;
      ram_wdata = a_wdata;
      ram_wren  = a_we;
      issue_rd  = !a_we;
    end else if (gnt_b) begin
      ram_addr  = b_addr;
      ram_wdata = b_wdata;
      ram_wren  = b_we;
      issue_rd  = !b_we;
      issue_own = 1'b1;
    end
  end

  // Read-return pipeline matching the RAM latency; owner bit set means port B.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_v <= '0;
      pipe_o <= '0;
    end else begin
      for (int i = READ_LAT - 1; i > 0; i--) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_o[i] <= pipe_o[i-1];
      end
      pipe_v[0] <= issue_rd;
      pipe_o[0] <= issue_own;
    end
  end

  assign ret_v    = pipe_v[READ_LAT-1] && !reset;
  assign a_rvalid = ret_v && !pipe_o[READ_LAT-1];
  assign b_rvalid = ret_v && pipe_o[READ_LAT-1];
  assign a_rdata  = a_rvalid ? ram_rdata : '0;
  assign b_rdata  = b_rvalid ? ram_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized bench with a cycle-level reference model; two DUTs at READ_LAT 1 and 3.
module tb_dmem_arbiter;

  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned DATA_W   = 24;
  localparam int unsigned MAX_WAIT = 4;

  logic clk = 1'b0;
  logic reset;
  logic a_req, a_we, b_req, b_we;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [DATA_W-1:0] a_wdata, b_wdata;

  logic a_gnt1, b_gnt1, a_rvalid1, b_rvalid1, ram_wren1;
  logic [DATA_W-1:0] a_rdata1, b_rdata1, ram_wdata1, ram_rdata1;
  logic [ADDR_W-1:0] ram_addr1;
  logic a_gnt3, b_gnt3, a_rvalid3, b_rvalid3, ram_wren3;
  logic [DATA_W-1:0] a_rdata3, b_rdata3, ram_wdata3, ram_rdata3;
  logic [ADDR_W-1:0] ram_addr3;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(1), .MAX_WAIT(MAX_WAIT)) u_dut1 (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt1), .a_rvalid(a_rvalid1), .a_rdata(a_rdata1),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt1), .b_rvalid(b_rvalid1), .b_rdata(b_rdata1),
    .ram_addr(ram_addr1), .ram_wdata(ram_wdata1), .ram_wren(ram_wren1), .ram_rdata(ram_rdata1)
  );

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(3), .MAX_WAIT(MAX_WAIT)) u_dut3 (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt3), .a_rvalid(a_rvalid3), .a_rdata(a_rdata3),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt3), .b_rvalid(b_rvalid3), .b_rdata(b_rdata3),
    .ram_addr(ram_addr3), .ram_wdata(ram_wdata3), .ram_wren(ram_wren3), .ram_rdata(ram_rdata3)
  );

  // RAM models: data captured at issue, delivered after the configured latency.
  logic [DATA_W-1:0] mem1 [256];
  logic [DATA_W-1:0] mem3 [256];
  logic [DATA_W-1:0] rp1;
  logic [DATA_W-1:0] rp3 [3];

  always @(posedge clk) begin
    if (ram_wren1) mem1[ram_addr1[7:0]] <= ram_wdata1;
    rp1 <= ram_wren1 ? ram_wdata1 : mem1[ram_addr1[7:0]];
  end
  assign ram_rdata1 = rp1;

  always @(posedge clk) begin
    if (ram_wren3) mem3[ram_addr3[7:0]] <= ram_wdata3;
    rp3[0] <= ram_wren3 ? ram_wdata3 : mem3[ram_addr3[7:0]];
    rp3[1] <= rp3[0];
    rp3[2] <= rp3[1];
  end
  assign ram_rdata3 = rp3[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Reference model: grant rules, reference memory and per-latency return rings.
  logic [DATA_W-1:0] ref_mem [256];
  logic              ev1_v [8];
  logic              ev1_o [8];
  logic [DATA_W-1:0] ev1_d [8];
  logic              ev3_v [8];
  logic              ev3_o [8];
  logic [DATA_W-1:0] ev3_d [8];
  int unsigned       wcnt   = 0;
  logic              prio_b = 1'b0;

  always @(negedge clk) begin : model
    logic ea, eb, fav_b, rd, own;
    logic [ADDR_W-1:0] ad;
    logic [DATA_W-1:0] wd;
    int s;
    s = cyc % 8;
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        ev1_v[i] = 1'b0;
        ev3_v[i] = 1'b0;
      end
      wcnt   = 0;
      prio_b = 1'b0;
      ea = 1'b0;
      eb = 1'b0;
    end else begin
`ifdef DMEM_ARB_RR_EN
      fav_b = prio_b;
`else
      fav_b = (wcnt == MAX_WAIT);
`endif
      ea = a_req && (!b_req || !fav_b);
      eb = b_req && !ea;
    end

    check("a_rvalid1", 32'(a_rvalid1), 32'(ev1_v[s] && !ev1_o[s]));
    check("b_rvalid1", 32'(b_rvalid1), 32'(ev1_v[s] && ev1_o[s]));
    check("a_rdata1", 32'(a_rdata1), (ev1_v[s] && !ev1_o[s]) ? 32'(ev1_d[s]) : 32'h0);
    check("b_rdata1", 32'(b_rdata1), (ev1_v[s] && ev1_o[s]) ? 32'(ev1_d[s]) : 32'h0);
    check("a_rvalid3", 32'(a_rvalid3), 32'(ev3_v[s] && !ev3_o[s]));
    check("b_rvalid3", 32'(b_rvalid3), 32'(ev3_v[s] && ev3_o[s]));
    check("a_rdata3", 32'(a_rdata3), (ev3_v[s] && !ev3_o[s]) ? 32'(ev3_d[s]) : 32'h0);
    check("b_rdata3", 32'(b_rdata3), (ev3_v[s] && ev3_o[s]) ? 32'(ev3_d[s]) : 32'h0);
    ev1_v[s] = 1'b0;
    ev3_v[s] = 1'b0;

    ad = ea ? a_addr : (eb ? b_addr : '0);
    wd = ea ? a_wdata : (eb ? b_wdata : '0);
    rd = (ea && !a_we) || (eb && !b_we);
    own = eb;
    check("a_gnt1", 32'(a_gnt1), 32'(ea));
    check("b_gnt1", 32'(b_gnt1), 32'(eb));
    check("a_gnt3", 32'(a_gnt3), 32'(ea));
    check("b_gnt3", 32'(b_gnt3), 32'(eb));
    check("ram_wren1", 32'(ram_wren1), 32'((ea && a_we) || (eb && b_we)));
    check("ram_addr1", 32'(ram_addr1), 32'(ad));
    check("ram_wdata1", 32'(ram_wdata1), 32'(wd));
    check("ram_addr3", 32'(ram_addr3), 32'(ad));

    if ((ea || eb) && !rd) ref_mem[ad[7:0]] = wd;
    if (rd) begin
      ev1_v[(cyc + 1) % 8] = 1'b1;
      ev1_o[(cyc + 1) % 8] = own;
      ev1_d[(cyc + 1) % 8] = ref_mem[ad[7:0]];
      ev3_v[(cyc + 3) % 8] = 1'b1;
      ev3_o[(cyc + 3) % 8] = own;
      ev3_d[(cyc + 3) % 8] = ref_mem[ad[7:0]];
    end

    if (!reset) begin
      if (b_req && !eb) wcnt = (wcnt < MAX_WAIT) ? wcnt + 1 : wcnt;
      else wcnt = 0;
      if (ea) prio_b = 1'b1;
      else if (eb) prio_b = 1'b0;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ADDR_W-1:0] rnd_addr();
    return {8'($urandom_range(0, 255)), 8'($urandom_range(0, 31))};
  endfunction

  logic [DATA_W-1:0] pre_d [32];
  logic a_took, b_took;

  initial begin
    reset = 1'b1;
    a_req = 1'b1; a_we = 1'b1; a_addr = 16'h0010; a_wdata = 24'h123456;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Preload the address window used by the rest of the run.
    for (int i = 0; i < 32; i++) begin
      pre_d[i] = 24'($urandom);
      a_req = 1'b1; a_we = 1'b1; a_addr = 16'(i); a_wdata = pre_d[i];
      tick();
    end

    // Write then immediate read-back on port A.
    a_we = 1'b1; a_addr = 16'h0010; a_wdata = 24'hABCDEF;
    tick();
    a_we = 1'b0;
    tick();
    a_req = 1'b0;
    @(negedge clk);
    check("rdback_valid", 32'(a_rvalid1), 32'h1);
    check("rdback_data", 32'(a_rdata1), 32'hABCDEF);
    check("rdback_b_quiet", 32'(b_rvalid1), 32'h0);
    tick();
    repeat (3) tick();

    // Alternating A/B reads observed on the latency-3 instance.
    for (int k = 0; k < 8; k++) begin
      a_req = (k < 4) && (k % 2 == 0); a_we = 1'b0; a_addr = 16'h0001;
      b_req = (k < 4) && (k % 2 == 1); b_we = 1'b0; b_addr = 16'h0002;
      @(negedge clk);
      check("alt_a_rvalid3", 32'(a_rvalid3), 32'((k == 3) || (k == 5)));
      check("alt_b_rvalid3", 32'(b_rvalid3), 32'((k == 4) || (k == 6)));
      if (k == 3 || k == 5) check("alt_a_rdata3", 32'(a_rdata3), 32'(pre_d[1]));
      if (k == 4 || k == 6) check("alt_b_rdata3", 32'(b_rdata3), 32'(pre_d[2]));
      tick();
    end
    a_req = 1'b0; b_req = 1'b0;

    // Both requesting continuously from a clean reset.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0003;
    b_req = 1'b1; b_we = 1'b0; b_addr = 16'h0004;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
`ifdef DMEM_ARB_RR_EN
      check("conflict_pattern", 32'(b_gnt1), 32'(k % 2 == 1));
`else
      check("conflict_pattern", 32'(b_gnt1), 32'(k % 5 == 4));
`endif
      tick();
    end
    a_req = 1'b0; b_req = 1'b0;
    repeat (4) tick();

    // Read in flight when reset arrives produces no return.
    a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0005;
    tick();
    a_req = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("flushed_rvalid", 32'(a_rvalid1 || a_rvalid3), 32'h0);
      tick();
    end

    // Randomized traffic with occasional drops and resets.
    a_took = 1'b0; b_took = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      a_took = a_gnt1;
      b_took = b_gnt1;
      tick();
      reset = ($urandom_range(0, 199) == 0);
      if (a_took || !a_req) begin
        a_req = ($urandom_range(0, 3) != 0);
        a_we = 1'($urandom_range(0, 1));
        a_addr = rnd_addr();
        a_wdata = 24'($urandom);
      end else if ($urandom_range(0, 15) == 0) begin
        a_req = 1'b0;
      end
      if (b_took || !b_req) begin
        b_req = ($urandom_range(0, 1) != 0);
        b_we = 1'($urandom_range(0, 1));
        b_addr = rnd_addr();
        b_wdata = 24'($urandom);
      end else if ($urandom_range(0, 15) == 0) begin
        b_req = 1'b0;
      end
    end
    reset = 1'b0; a_req = 1'b0; b_req = 1'b0;
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 24-bit data RAM between the ASIP core load/store port (port A) and a secondary requester (port B), e.g. the image loader or debug port.
- Sits between `asip`/loader and the RAM instance in `processor`.
- Grants at most one access per cycle.
- Tracks in-flight reads across the RAM's fixed read latency and returns data to the owner.
- Guarantees port B forward progress against a continuously requesting core.

Parameters:
- ADDR_W, 16, address width (matches `pc`/`aluRes` width).
- DATA_W, 24, RAM word width.
- READ_LAT, 1, RAM read latency in cycles; legal range 1..4.
- MAX_WAIT, 4, consecutive denied cycles of port B before B is forced to win; legal 1..15.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- a_req  in  1  core access request; held with a_we/a_addr/a_wdata until a_gnt.
- a_we  in  1  1 = write, 0 = read.
- a_addr  in  ADDR_W  core address.
- a_wdata  in  DATA_W  core write data.
- a_gnt  out  1  access issued to RAM this cycle.
- a_rvalid  out  1  a_rdata valid (read return for port A).
- a_rdata  out  DATA_W  read data.
- b_req, b_we, b_addr, b_wdata  in  same as port A, for port B.
- b_gnt, b_rvalid, b_rdata  out  same as port A, for port B.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_wren  out  1  RAM write enable.
- ram_rdata  in  DATA_W  RAM read data, valid READ_LAT cycles after address.

Behaviour:
- Reset (synchronous, active-high):
  - Read pipeline, starvation counter and RR pointer are cleared.
  - While reset is high: a_gnt = b_gnt = 0, ram_wren = 0, a_rvalid = b_rvalid = 0.
  - ram_addr, ram_wdata and rdata outputs are 0.
- Grant is combinational in the issue cycle:
  - Only one of a_gnt/b_gnt is high at a time.
  - ram_addr, ram_wdata and ram_wren = req & we are muxed from the winner.
  - With no winner: ram_wren = 0 and ram_addr holds the value 0.
- Arbitration (default, fixed priority):
  - A only -> A. B only -> B.
  - Both -> A, unless wait_cnt == MAX_WAIT, in which case B wins.
- wait_cnt (registered):
  - Increments each cycle b_req = 1 and b_gnt = 0, saturating at MAX_WAIT.
  - Clears when b_gnt = 1 or b_req = 0.
- Handshake:
  - A request completes in the cycle its gnt is high.
  - The requester may change inputs or drop req the following cycle.
  - Dropping req before grant is allowed; no state is retained for it.
- Read return:
  - Pipeline of READ_LAT stages carrying {valid, owner}, loaded when a granted access has we = 0.
  - x_rvalid is high exactly READ_LAT cycles after x_gnt for a read. It is a 1-cycle pulse per read; back-to-back reads produce back-to-back pulses.
  - a_rdata = b_rdata = ram_rdata, gated to 0 when the respective rvalid = 0.
- Writes produce no rvalid.
- Read-after-write to the same address in consecutive cycles returns the new data (RAM write-first ordering is the RAM's responsibility; the arbiter adds no reordering).
- Simultaneous grant and return: a new issue and a return in the same cycle are independent; no stall.
- Reset mid-operation: in-flight reads are discarded; no rvalid after reset deasserts for accesses issued before reset.
- No full/empty condition: the pipeline depth equals READ_LAT and accepts one entry per cycle.

Optional Feature:
- DMEM_ARB_RR_EN defined:
  - On conflict (both req), the winner alternates using a 1-bit last-winner pointer, updated on every grant.
  - After reset, A is favoured first.
  - The wait_cnt/MAX_WAIT logic is removed (B waits at most 1 cycle).
- Undefined: fixed priority with starvation guard as above.

Test Plan:
- Reset with a_req = 1, a_we = 1 -> a_gnt = 0, ram_wren = 0 throughout reset; first cycle after reset a_gnt = 1, ram_wren = 1.
- A write addr 0x0010 data 0xABCDEF, next cycle A read 0x0010 (READ_LAT = 1) -> a_gnt both cycles; a_rvalid = 1 with a_rdata = 0xABCDEF exactly 1 cycle after the read grant; b_rvalid stays 0.
- a_req and b_req both held high continuously, MAX_WAIT = 4 -> grant pattern A,A,A,A,B repeating (B every 5th cycle).
- READ_LAT = 3, alternating A/B reads to 0x0001/0x0002 on consecutive cycles -> rvalid pulses alternate A,B starting 3 cycles after the first grant, each with correct owner data.
- Issue A read, assert reset on the next cycle for 1 cycle -> no a_rvalid ever produced for that read.
- With DMEM_ARB_RR_EN, both requesting continuously -> grants A,B,A,B...
